// File: rtl/checker_pkg.sv
// Shared state encoding and default constants for the on-board response checker.
// No logic here; the top and the MISR import it.
package checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  localparam logic [15:0] DEF_SIG_POLY  = 16'hB400;
  localparam logic [15:0] SIG_SEED      = 16'hFFFF;
  localparam int          DEF_BLINK_DIV = 12_500_000;

endpackage

// File: rtl/misr.sv
// 16-bit Galois MISR: clear loads the seed, enable folds one data word per cycle.
// Single-cycle update, no backpressure (accepts whenever enable is high).
module misr
  import checker_pkg::*;
#(
  parameter logic [15:0] POLY = DEF_SIG_POLY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] data,
  output logic [15:0] sig
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= 16'h0000;
    end else if (clear) begin
      sig <= SIG_SEED;
    end else if (enable) begin
      sig <= (sig >> 1) ^ (sig[0] ? POLY : 16'h0000) ^ data;
    end
  end

endmodule

// File: rtl/response_checker.sv
// Compares DUT responses to golden values, counts mismatches, signs responses, drives a status LED.
// Results visible one edge after each accepted sample; never stalls the sample stream.
module response_checker
  import checker_pkg::*;
#(
  parameter int          OUTPUT_SIZE = 1,
  parameter int          NUM_VECTORS = 16,
  parameter int          ERR_WIDTH   = 8,
  parameter logic [15:0] SIG_POLY    = DEF_SIG_POLY,
  parameter int          BLINK_DIV   = DEF_BLINK_DIV,
  localparam int         IDX_W       = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sample_valid,
  input  logic [OUTPUT_SIZE-1:0] probe,
  input  logic [OUTPUT_SIZE-1:0] expected,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_WIDTH-1:0]   err_count,
  output logic [IDX_W-1:0]       first_err_idx,
  output logic [15:0]            signature,
  output logic                   led
);

  localparam int                   BLK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_VECTORS - 1);
  localparam logic [BLK_W-1:0]     BLK_LAST = BLK_W'(BLINK_DIV - 1);
  localparam logic [ERR_WIDTH-1:0] ERR_MAX  = '1;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [BLK_W-1:0] blink_cnt;
  logic             accept;
  logic             mismatch;
  logic             restart;
  logic [15:0]      probe_ext;

  assign accept    = (state == RUN) && sample_valid;
  assign mismatch  = (probe != expected);
  assign restart   = (state != RUN) && start;
  assign probe_ext = 16'(probe);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        // Error count never wraps back to zero, so zero here means a clean run so far.
        if (accept && (idx == LAST_IDX)) begin
          state_nxt = ((err_count == '0) && !mismatch) ? PASS : FAIL;
        end
      end
      PASS, FAIL: if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx           <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
    end else if (restart) begin
      idx           <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
    end else if (accept) begin
      idx <= idx + 1'b1;
      if (mismatch) begin
        if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
        if (err_count == '0) first_err_idx <= idx;
      end
    end
  end

  misr #(
    .POLY(SIG_POLY)
  ) u_misr (
    .clk   (clk),
    .rst   (rst),
    .clear (restart),
    .enable(accept),
    .data  (probe_ext),
    .sig   (signature)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == PASS) || (state_nxt == FAIL);
      pass <= (state_nxt == PASS);
    end
  end

  // LED starts lit on FAIL entry and flips each time the divider wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led       <= 1'b0;
      blink_cnt <= '0;
    end else if (state_nxt == PASS) begin
      led       <= 1'b1;
      blink_cnt <= '0;
    end else if (state_nxt == FAIL) begin
      if (state != FAIL) begin
        led       <= 1'b1;
        blink_cnt <= '0;
      end else if (blink_cnt == BLK_LAST) begin
        led       <= ~led;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end else begin
      led       <= 1'b0;
      blink_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_response_checker.sv
// Randomized scoreboard bench: three checker instances (16 vectors, 1 vector, 2-bit error counter).
// Expected results are queued at stimulus time and popped when each instance raises done.
module tb_response_checker;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst;
  logic        start_s[3];
  logic        sv_s[3];
  logic        pr_s[3];
  logic        ex_s[3];
  logic        busy_o[3];
  logic        done_o[3];
  logic        pass_o[3];
  logic        led_o[3];
  logic [15:0] sig_o[3];
  logic [7:0]  err0, err1;
  logic [1:0]  err2;
  logic [3:0]  fe0, fe2;
  logic [0:0]  fe1;

  response_checker #(.NUM_VECTORS(16), .ERR_WIDTH(8), .BLINK_DIV(4)) u0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .sample_valid(sv_s[0]),
    .probe(pr_s[0]), .expected(ex_s[0]), .busy(busy_o[0]), .done(done_o[0]),
    .pass(pass_o[0]), .err_count(err0), .first_err_idx(fe0),
    .signature(sig_o[0]), .led(led_o[0]));

  response_checker #(.NUM_VECTORS(1), .ERR_WIDTH(8), .BLINK_DIV(4)) u1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .sample_valid(sv_s[1]),
    .probe(pr_s[1]), .expected(ex_s[1]), .busy(busy_o[1]), .done(done_o[1]),
    .pass(pass_o[1]), .err_count(err1), .first_err_idx(fe1),
    .signature(sig_o[1]), .led(led_o[1]));

  response_checker #(.NUM_VECTORS(16), .ERR_WIDTH(2), .BLINK_DIV(4)) u2 (
    .clk(clk), .rst(rst), .start(start_s[2]), .sample_valid(sv_s[2]),
    .probe(pr_s[2]), .expected(ex_s[2]), .busy(busy_o[2]), .done(done_o[2]),
    .pass(pass_o[2]), .err_count(err2), .first_err_idx(fe2),
    .signature(sig_o[2]), .led(led_o[2]));

  typedef struct {
    int err;
    int first;
    int sig;
    bit pass;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  bit   vp[64], ve[64];
  int   checks = 0;
  int   errors = 0;
  bit   dp[3];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endtask

  // Reference: count mismatches, note the first, fold probes through the signature polynomial.
  function automatic exp_t model(input int n, input int ew);
    exp_t        r;
    bit   [15:0] s = 16'hFFFF;
    int          e = 0;
    int          f = 0;
    int          cap = (1 << ew) - 1;
    for (int i = 0; i < n; i++) begin
      if (vp[i] != ve[i]) begin
        if (e == 0) f = i;
        e++;
      end
      s = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000) ^ {15'b0, vp[i]};
    end
    r.err   = (e > cap) ? cap : e;
    r.first = f;
    r.sig   = int'(s);
    r.pass  = (e == 0);
    return r;
  endfunction

  task automatic on_done(input int k, input int err, input int first);
    exp_t e;
    bit   have = 0;
    if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1; end
    if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1; end
    if (k == 2 && q2.size() > 0) begin e = q2.pop_front(); have = 1; end
    chk($sformatf("u%0d_result_queued", k), int'(have), 1);
    if (have) begin
      chk($sformatf("u%0d_err_count", k), err, e.err);
      chk($sformatf("u%0d_first_err_idx", k), first, e.first);
      chk($sformatf("u%0d_signature", k), int'(sig_o[k]), e.sig);
      chk($sformatf("u%0d_pass", k), int'(pass_o[k]), int'(e.pass));
      chk($sformatf("u%0d_busy_when_done", k), int'(busy_o[k]), 0);
    end
  endtask

  always @(negedge clk) begin
    if (done_o[0] === 1'b1 && !dp[0]) on_done(0, int'(err0), int'(fe0));
    if (done_o[1] === 1'b1 && !dp[1]) on_done(1, int'(err1), int'(fe1));
    if (done_o[2] === 1'b1 && !dp[2]) on_done(2, int'(err2), int'(fe2));
    for (int k = 0; k < 3; k++) dp[k] = (done_o[k] === 1'b1);
  end

  // Issues one run from vp/ve; returns on the first negedge showing done (or after a bound).
  task automatic run(input int k, input int n, input bit gaps, input bit sv_with_start);
    exp_t e;
    bit   got = 0;
    e = model(n, (k == 2) ? 2 : 8);
    if (k == 0) q0.push_back(e);
    if (k == 1) q1.push_back(e);
    if (k == 2) q2.push_back(e);
    @(posedge clk); #1;
    start_s[k] = 1'b1;
    sv_s[k]    = sv_with_start;
    pr_s[k]    = 1'b1;
    ex_s[k]    = 1'b0;
    @(posedge clk); #1;
    start_s[k] = 1'b0;
    sv_s[k]    = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          sv_s[k]    = 1'b0;
          pr_s[k]    = 1'($urandom_range(0, 1));
          ex_s[k]    = 1'($urandom_range(0, 1));
          start_s[k] = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          start_s[k] = 1'b0;
        end
      end
      sv_s[k] = 1'b1;
      pr_s[k] = vp[i];
      ex_s[k] = ve[i];
      @(posedge clk); #1;
    end
    sv_s[k] = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (done_o[k] === 1'b1) got = 1;
    end
    chk($sformatf("u%0d_done_within_bound", k), int'(got), 1);
  endtask

  task automatic fill_random(input int n, input int mis_ratio);
    for (int i = 0; i < n; i++) begin
      vp[i] = 1'($urandom_range(0, 1));
      ve[i] = ($urandom_range(0, mis_ratio) == 0) ? ~vp[i] : vp[i];
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0; sv_s[k] = 1'b0; pr_s[k] = 1'b0; ex_s[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d_reset_busy", k), int'(busy_o[k]), 0);
      chk($sformatf("u%0d_reset_done", k), int'(done_o[k]), 0);
      chk($sformatf("u%0d_reset_pass", k), int'(pass_o[k]), 0);
      chk($sformatf("u%0d_reset_sig", k), int'(sig_o[k]), 0);
      chk($sformatf("u%0d_reset_led", k), int'(led_o[k]), 0);
    end
    chk("u0_reset_err", int'(err0), 0);
    chk("u0_reset_first", int'(fe0), 0);

    // All matching; a mismatching sample alongside start must be ignored.
    for (int i = 0; i < 16; i++) begin vp[i] = 1'($urandom_range(0, 1)); ve[i] = vp[i]; end
    run(0, 16, 0, 1);
    chk("u0_allmatch_led", int'(led_o[0]), 1);
    chk("u0_allmatch_err", int'(err0), 0);

    // Single-vector runs from the seed.
    vp[0] = 1'b1; ve[0] = 1'b1;
    run(1, 1, 0, 0);
    chk("u1_sig_probe1", int'(sig_o[1]), 32'hCBFE);
    vp[0] = 1'b0; ve[0] = 1'b0;
    run(1, 1, 0, 1);
    chk("u1_sig_probe0", int'(sig_o[1]), 32'hCBFF);
    chk("u1_pass_probe0", int'(pass_o[1]), 1);
    vp[0] = 1'b1; ve[0] = 1'b0;
    run(1, 1, 0, 0);

    // Mismatches at 3 and 9, then check the blink pattern.
    for (int i = 0; i < 16; i++) begin
      vp[i] = 1'($urandom_range(0, 1));
      ve[i] = (i == 3 || i == 9) ? ~vp[i] : vp[i];
    end
    run(0, 16, 0, 0);
    chk("u0_two_err_count", int'(err0), 2);
    chk("u0_two_err_first", int'(fe0), 3);
    for (int j = 0; j < 12; j++) begin
      chk($sformatf("u0_led_blink_%0d", j), int'(led_o[0]), int'(((j / 4) % 2) == 0));
      @(negedge clk);
    end

    // Saturating 2-bit counter.
    for (int i = 0; i < 16; i++) begin vp[i] = 1'($urandom_range(0, 1)); ve[i] = ~vp[i]; end
    run(2, 16, 0, 1);
    chk("u2_saturated", int'(err2), 3);

    // Same data gapless then gapped with stray start pulses.
    for (int r = 0; r < 4; r++) begin
      fill_random(16, 5);
      run(0, 16, 0, 0);
      run(0, 16, 1, 0);
      fill_random(16, 2);
      run(2, 16, 1, 1);
    end

    // Reset mid-run after 5 mismatching samples.
    @(posedge clk); #1 start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sv_s[0] = 1'b1; pr_s[0] = 1'b1; ex_s[0] = 1'b0;
      @(posedge clk); #1;
    end
    sv_s[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("u0_midrun_rst_busy", int'(busy_o[0]), 0);
    chk("u0_midrun_rst_err", int'(err0), 0);
    chk("u0_midrun_rst_sig", int'(sig_o[0]), 0);
    chk("u0_midrun_rst_led", int'(led_o[0]), 0);
    @(posedge clk); #1 rst = 1'b0;

    fill_random(16, 3);
    run(0, 16, 1, 0);

    repeat (2) @(negedge clk);
    chk("pending_results", q0.size() + q1.size() + q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
